// File: rtl/routine_pkg.sv
// routine_pkg: shared types and constants for the stopwatch display routine.
// State encoding, active-low 7-segment glyphs and bundle field offsets.
package routine_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s0;
    logic [3:0] h1;
    logic [3:0] h0;
  } bcd_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int LED_RED_LSB = 36;
  localparam int LED_GRN_LSB = 28;
  localparam int HEX3_LSB    = 21;
  localparam int HEX2_LSB    = 14;
  localparam int HEX1_LSB    = 7;
  localparam int HEX0_LSB    = 0;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_FIVE = 4'd5;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-low 7-segment pattern (bit 0 = a).
// Codes 10..15 blank the digit.
module seg7_decode
  import routine_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // glyph lookup
  always_comb begin
    seg = SEG_BLANK;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/routine_stopwatch.sv
// routine_stopwatch: SS.hh stopwatch packed into a 46-bit display routine.
// Optional lap hold display freeze: define LAP_HOLD_EN.
module routine_stopwatch
  import routine_pkg::*;
#(
  parameter int TICK_DIV = 500000
)
(
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        StartStop,
  input  logic        Clear,
  input  logic        Lap,
  output logic [45:0] Routine
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] sync3;
  logic [1:0] ev;
  logic       ev_ss;
  logic       ev_clr;

  state_t     state;
  state_t     state_n;
  logic       go_idle;

  logic [PW-1:0] presc;
  logic          tick;

  bcd_t       bcd;
  bcd_t       bcd_n;
  bcd_t       shown;
  logic       sec_carry;
  logic       wrap_hit;

  logic [7:0] walker;
  logic       wrap;
  logic       hold;

  logic [6:0] hex3;
  logic [6:0] hex2;
  logic [6:0] hex1;
  logic [6:0] hex0;

  // two-flop sync, then a registered rising-edge pulse
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      ev    <= '0;
    end else begin
      sync1 <= {Clear, StartStop};
      sync2 <= sync1;
      sync3 <= sync2;
      ev    <= sync2 & ~sync3;
    end
  end

  assign ev_ss  = ev[0];
  assign ev_clr = ev[1];

  // state register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next state; clear beats start/stop
  always_comb begin
    state_n = state;
    go_idle = 1'b0;
    if (ev_clr) begin
      state_n = IDLE;
      go_idle = 1'b1;
    end else if (ev_ss) begin
      case (state)
        IDLE:    state_n = RUN;
        RUN:     state_n = PAUSE;
        PAUSE:   state_n = RUN;
        default: state_n = IDLE;
      endcase
    end
  end

  assign tick = (state == RUN) && (presc == TICK_LAST);

  // prescaler: runs in RUN, holds in PAUSE, zero in IDLE
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      presc <= '0;
    end else if (go_idle || tick) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= presc + 1'b1;
    end
  end

  // BCD ripple increment on a tick
  always_comb begin
    bcd_n     = bcd;
    sec_carry = 1'b0;
    wrap_hit  = 1'b0;
    if (tick) begin
      if (bcd.h0 != BCD_NINE) begin
        bcd_n.h0 = bcd.h0 + 4'd1;
      end else begin
        bcd_n.h0 = 4'd0;
        if (bcd.h1 != BCD_NINE) begin
          bcd_n.h1 = bcd.h1 + 4'd1;
        end else begin
          bcd_n.h1  = 4'd0;
          sec_carry = 1'b1;
          if (bcd.s0 != BCD_NINE) begin
            bcd_n.s0 = bcd.s0 + 4'd1;
          end else begin
            bcd_n.s0 = 4'd0;
            if (bcd.s1 != BCD_FIVE) begin
              bcd_n.s1 = bcd.s1 + 4'd1;
            end else begin
              bcd_n.s1 = 4'd0;
              wrap_hit = 1'b1;
            end
          end
        end
      end
    end
  end

  // digits, seconds walker and sticky wrap flag
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      bcd    <= '0;
      walker <= 8'h01;
      wrap   <= 1'b0;
    end else if (go_idle) begin
      bcd    <= '0;
      walker <= 8'h01;
      wrap   <= 1'b0;
    end else begin
      bcd <= bcd_n;
      if (sec_carry) begin
        walker <= {walker[6:0], walker[7]};
      end
      if (wrap_hit) begin
        wrap <= 1'b1;
      end
    end
  end

`ifdef LAP_HOLD_EN
  logic lap1;
  logic lap2;
  logic lap3;
  logic ev_lap;
  bcd_t snap;

  // lap input sync and edge pulse
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      lap1   <= 1'b0;
      lap2   <= 1'b0;
      lap3   <= 1'b0;
      ev_lap <= 1'b0;
    end else begin
      lap1   <= Lap;
      lap2   <= lap1;
      lap3   <= lap2;
      ev_lap <= lap2 & ~lap3;
    end
  end

  // lap toggles hold in RUN; snapshot taken as hold sets
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      hold <= 1'b0;
      snap <= '0;
    end else if (go_idle) begin
      hold <= 1'b0;
    end else if (ev_lap && (state == RUN)) begin
      hold <= ~hold;
      if (!hold) begin
        snap <= bcd;
      end
    end
  end

  assign shown = hold ? snap : bcd;
`else
  logic unused_lap;

  assign unused_lap = Lap;
  assign hold       = 1'b0;
  assign shown      = bcd;
`endif

  seg7_decode u_hex3 (.bcd(shown.s1), .seg(hex3));
  seg7_decode u_hex2 (.bcd(shown.s0), .seg(hex2));
  seg7_decode u_hex1 (.bcd(shown.h1), .seg(hex1));
  seg7_decode u_hex0 (.bcd(shown.h0), .seg(hex0));

  // pack the display bundle
  always_comb begin
    Routine = '0;
    Routine[LED_RED_LSB +: 10] = {wrap, 1'b0, walker};
    Routine[LED_GRN_LSB +: 8]  = {4'b0000, hold,
                                  state == PAUSE,
                                  state == RUN,
                                  state == IDLE};
    Routine[HEX3_LSB +: 7] = hex3;
    Routine[HEX2_LSB +: 7] = hex2;
    Routine[HEX1_LSB +: 7] = hex1;
    Routine[HEX0_LSB +: 7] = hex0;
  end

endmodule

// File: tb/tb_routine_stopwatch.sv
// tb_routine_stopwatch: directed stimulus with a time-count reference model.
// Define LAP_HOLD_EN to also exercise the lap hold display.
module tb_routine_stopwatch;

  localparam int TD = 4;
  localparam int SS = 0;
  localparam int CL = 1;
  localparam int LP = 2;

  localparam logic [6:0] G0 = 7'h40;
  localparam logic [6:0] G1 = 7'h79;
  localparam logic [6:0] G2 = 7'h24;
  localparam logic [6:0] G3 = 7'h30;
  localparam logic [6:0] G4 = 7'h19;
  localparam logic [6:0] G5 = 7'h12;
  localparam logic [6:0] G9 = 7'h10;

  localparam logic [45:0] RST = {10'h001, 8'h01, G0, G0, G0, G0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss = 1'b0;
  logic        cl = 1'b0;
  logic        lp = 1'b0;
  logic [45:0] routine;

  int total = 0;
  int bad = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  routine_stopwatch #(.TICK_DIV(TD)) dut (
    .Clock     (clk),
    .Reset_n   (rst_n),
    .StartStop (ss),
    .Clear     (cl),
    .Lap       (lp),
    .Routine   (routine)
  );

  always #5 clk = ~clk;

  // model: state 0 idle / 1 run / 2 pause, elapsed time in hundredths
  int       m_st = 0;
  int       m_pre = 0;
  int       m_cnt = 0;
  int       m_car = 0;
  int       m_snap = 0;
  bit       m_wrap = 1'b0;
  bit       m_hold = 1'b0;
  bit [4:0] h_ss = '0;
  bit [4:0] h_cl = '0;
  bit [4:0] h_lp = '0;
  bit       e_ss;
  bit       e_cl;
  bit       e_lp;
  bit       m_tick;

  // an input acts on the third edge after its first high sample
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_st = 0; m_pre = 0; m_cnt = 0; m_car = 0;
      m_wrap = 1'b0; m_hold = 1'b0;
      h_ss = '0; h_cl = '0; h_lp = '0;
    end else begin
      e_ss = h_ss[2] && !h_ss[3];
      e_cl = h_cl[2] && !h_cl[3];
      e_lp = h_lp[2] && !h_lp[3];
      h_ss = {h_ss[3:0], ss};
      h_cl = {h_cl[3:0], cl};
      h_lp = {h_lp[3:0], lp};
      m_tick = (m_st == 1) && (m_pre == TD - 1);
      if (e_cl) begin
        m_st = 0; m_pre = 0; m_cnt = 0; m_car = 0;
        m_wrap = 1'b0; m_hold = 1'b0;
      end else begin
`ifdef LAP_HOLD_EN
        if (e_lp && m_st == 1) begin
          if (!m_hold) m_snap = m_cnt;
          m_hold = !m_hold;
        end
`endif
        if (m_tick) begin
          m_pre = 0;
          if (m_cnt % 100 == 99) m_car++;
          if (m_cnt == 5999) m_wrap = 1'b1;
          m_cnt = (m_cnt + 1) % 6000;
        end else if (m_st == 1) begin
          m_pre++;
        end
        if (e_ss) m_st = (m_st == 1) ? 2 : 1;
      end
    end
  end

  function automatic logic [45:0] exp_vec();
    int c;
    logic [7:0] w;
    c = m_hold ? m_snap : m_cnt;
    w = 8'h01 << (m_car % 8);
    return {m_wrap, 1'b0, w, 4'b0000, m_hold,
            m_st == 2, m_st == 1, m_st == 0,
            seg_tab[c / 1000], seg_tab[(c / 100) % 10],
            seg_tab[(c / 10) % 10], seg_tab[c % 10]};
  endfunction

  // every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      total++;
      if (routine !== exp_vec()) begin
        bad++;
        $display("FAIL model t=%0t routine got %h want %h",
                 $time, routine, exp_vec());
      end
    end
  end

  task automatic chk(input string name, input logic [45:0] got,
                     input logic [45:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      SS: ss = v;
      CL: cl = v;
      default: lp = v;
    endcase
  endtask

  // returns on the negedge right after the event took effect
  task automatic press(input int which);
    drive(which, 1'b1);
    repeat (2) @(negedge clk);
    drive(which, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_vec", routine, RST);
    rst_n = 1'b1;

    ss = 1'b1;
    repeat (20) @(negedge clk);
    chk("held_level_one_event", 46'(routine[35:28]), 46'(8'h02));
    ss = 1'b0;
    press(CL);
    chk("clear_to_idle", routine, RST);

    press(SS);
    repeat (1600) @(negedge clk);
    chk("run400_hex", 46'(routine[27:0]), 46'({G0, G4, G0, G0}));
    chk("run400_red", 46'(routine[45:36]), 46'(10'h010));
    chk("run400_grn", 46'(routine[35:28]), 46'(8'h02));

    press(CL);
    press(SS);
    repeat (6) @(negedge clk);
    press(SS);
    chk("pause_grn", 46'(routine[35:28]), 46'(8'h04));
    chk("pause_hex0", 46'(routine[6:0]), 46'(G2));
    repeat (50) @(negedge clk);
    chk("pause_hold_hex0", 46'(routine[6:0]), 46'(G2));
    press(SS);
    @(negedge clk);
    chk("resume_pre_tick", 46'(routine[6:0]), 46'(G2));
    @(negedge clk);
    chk("resume_tick", 46'(routine[6:0]), 46'(G3));

    press(CL);
    press(SS);
    repeat (23996) @(negedge clk);
    chk("at_5999_hex", 46'(routine[27:0]), 46'({G5, G9, G9, G9}));
    chk("at_5999_red", 46'(routine[45:36]), 46'(10'h008));
    repeat (4) @(negedge clk);
    chk("wrap_hex", 46'(routine[27:0]), 46'({G0, G0, G0, G0}));
    chk("wrap_red", 46'(routine[45:36]), 46'(10'h210));
    press(CL);
    chk("wrap_cleared", routine, RST);

    press(SS);
    repeat (30) @(negedge clk);
    cl = 1'b1;
    ss = 1'b1;
    repeat (2) @(negedge clk);
    cl = 1'b0;
    ss = 1'b0;
    repeat (2) @(negedge clk);
    chk("clear_priority", routine, RST);

`ifdef LAP_HOLD_EN
    press(SS);
    repeat (490) @(negedge clk);
    press(LP);
    chk("lap_set_hex", 46'(routine[27:0]), 46'({G0, G1, G2, G3}));
    chk("lap_set_grn", 46'(routine[35:28]), 46'(8'h0a));
    repeat (396) @(negedge clk);
    chk("lap_frozen_hex", 46'(routine[27:0]), 46'({G0, G1, G2, G3}));
    press(LP);
    chk("lap_release_hex", 46'(routine[27:0]), 46'({G0, G2, G2, G3}));
    chk("lap_release_grn", 46'(routine[35:28]), 46'(8'h02));
    press(CL);
`endif

    press(SS);
    repeat (37) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", routine, RST);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("after_reset_idle", routine, RST);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
